// File: rtl/simt_warp_scheduler.sv
// Round-robin warp scheduler feeding the SIMT fetch stage.
// Keeps per-warp state, PC and thread mask. Offers one READY warp per cycle.
module simt_warp_scheduler #(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned WID_W      = $clog2(NUM_WARPS),
    parameter int unsigned WARP_SIZE  = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  launch_valid,
    input  logic [WID_W-1:0]      launch_id,
    input  logic [DATA_WIDTH-1:0] launch_pc,
    input  logic [WARP_SIZE-1:0]  launch_mask,
    output logic                  launch_err,
    input  logic                  upd_valid,
    input  logic [WID_W-1:0]      upd_id,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic [WARP_SIZE-1:0]  upd_mask,
    input  logic                  upd_exit,
    output logic                  warp_valid,
    output logic [WID_W-1:0]      warp_id,
    output logic [DATA_WIDTH-1:0] warp_pc,
    output logic [WARP_SIZE-1:0]  warp_mask,
    input  logic                  issue_ack,
    output logic [NUM_WARPS-1:0]  ready_mask,
    output logic                  busy
);

    typedef enum logic [1:0] {StInactive, StReady, StInFlight, StDone} warp_state_e;

    warp_state_e           state_q [NUM_WARPS];
    warp_state_e           state_d [NUM_WARPS];
    logic [DATA_WIDTH-1:0] pc_q    [NUM_WARPS];
    logic [DATA_WIDTH-1:0] pc_d    [NUM_WARPS];
    logic [WARP_SIZE-1:0]  mask_q  [NUM_WARPS];
    logic [WARP_SIZE-1:0]  mask_d  [NUM_WARPS];
    logic [WID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  launch_err_q, launch_err_d;

    logic [WID_W-1:0] sel;
    logic [WID_W-1:0] idx;
    logic             any_ready;
    logic             do_issue;
    logic             do_update;

    // Select the first READY warp at or after rr_ptr; scanning offsets downward
    // lets the smallest offset win.
    always_comb begin
        sel       = '0;
        idx       = '0;
        any_ready = 1'b0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            idx = rr_ptr_q + WID_W'(i);
            if (state_q[idx] == StReady) begin
                sel       = idx;
                any_ready = 1'b1;
            end
        end
    end

    // Offer outputs and status flags, all derived from registered state.
    always_comb begin
        warp_valid = enable & any_ready & ~flush;
        warp_id    = warp_valid ? sel : '0;
        warp_pc    = warp_valid ? pc_q[sel] : '0;
        warp_mask  = warp_valid ? mask_q[sel] : '0;
        busy       = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            ready_mask[i] = (state_q[i] == StReady);
            busy          = busy | (state_q[i] == StReady) | (state_q[i] == StInFlight);
        end
        launch_err = launch_err_q;
    end

    // Next-state: issue, update, flush and launch all resolve against current state,
    // so events on different warps never interfere.
    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            mask_d[i]  = mask_q[i];
        end
        rr_ptr_d     = rr_ptr_q;
        launch_err_d = 1'b0;

        // warp_valid is already low during flush, so flush also blocks issue.
        do_issue  = warp_valid & issue_ack;
        do_update = upd_valid & ~flush & (state_q[upd_id] == StInFlight);

        if (do_issue) begin
            state_d[sel] = StInFlight;
            rr_ptr_d     = sel + WID_W'(1);
        end

        if (do_update) begin
            if (upd_exit || (upd_mask == '0)) begin
                state_d[upd_id] = StDone;
            end else begin
                state_d[upd_id] = StReady;
                pc_d[upd_id]    = upd_pc;
                mask_d[upd_id]  = upd_mask;
            end
        end

        if (flush) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (state_q[i] == StInFlight) state_d[i] = StReady;
            end
        end

        if (launch_valid) begin
            if ((state_q[launch_id] == StInactive) || (state_q[launch_id] == StDone)) begin
                state_d[launch_id] = (launch_mask == '0) ? StDone : StReady;
                pc_d[launch_id]    = launch_pc;
                mask_d[launch_id]  = launch_mask;
            end else begin
                launch_err_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= StInactive;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
            end
            rr_ptr_q     <= '0;
            launch_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
                mask_q[i]  <= mask_d[i];
            end
            rr_ptr_q     <= rr_ptr_d;
            launch_err_q <= launch_err_d;
        end
    end

endmodule
